alu_sequencer: RTL and testbench
================================

# alu_sequencer

Execute-stage issuer that drives the combinational 32-bit ALU (3-bit op, `a`/`b` in, `result`/`zero` out) from decoded RV32I OP/OP-IMM instructions. It maps funct3/funct7 to ALU op codes and presents operands. It emulates SLTU and SRA, which the ALU lacks, as multi-pass ALU sequences, registering the final result behind a valid/ready output handshake. It sits between decode and writeback and is the only master of the ALU ports.

## Interface
- No parameters. Data width is fixed at 32 and ALU op width is fixed at 3.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  decoded instruction offered.
- `in_ready`  out  1  high only in IDLE.
- `in_funct3`  in  3  RV32I funct3.
- `in_alt`  in  1  funct7[5] (instr bit 30).
- `in_is_imm`  in  1  1 selects `in_imm` as operand B; 0 selects `in_rs2`.
- `in_rs1`, `in_rs2`, `in_imm`  in  32 each  operand values; `in_imm` is already sign-extended.
- `in_rd`  in  5  destination tag, passed through.
- `alu_a`, `alu_b`  out  32  ALU operands.
- `alu_op`  out  3  ALU op: ADD 000, SUB 001, AND 010, OR 011, XOR 100, SLT 101, SLL 110, SRL 111.
- `alu_result`  in  32  ALU result.
- `alu_zero`  in  1  ALU zero flag.
- `out_valid`  out  1  result held.
- `out_ready`  in  1  consumer accepts.
- `out_data`  out  32  final result.
- `out_rd`  out  5  latched `in_rd`.
- `out_zero`  out  1  `out_data == 0`.
- `out_illegal`  out  1  unsupported encoding; `out_data` = 0.

## Operation
- FSM states: IDLE, EXEC, DONE.
  - IDLE→EXEC on `in_valid && in_ready`. All inputs are latched; B = `in_is_imm ? in_imm : in_rs2`; pass counter p = 0.
  - EXEC: each cycle drives one ALU pass and captures `alu_result` into temp T0/T1 or the result register at the next edge. On the final pass → DONE.
  - DONE→IDLE on `out_valid && out_ready`.
- Single pass (p0), funct3 mapping:
  - 000: ADD, or SUB when alt=1 and not imm.
  - 001: SLL.
  - 010: SLT.
  - 100: XOR.
  - 101: SRL when alt=0.
  - 110: OR.
  - 111: AND.
- SLTU (011):
  - p0: XOR(A, 0x80000000) → T0.
  - p1: XOR(B, 0x80000000) → T1.
  - p2: SLT(T0, T1) → result.
- SRA (101, alt=1); shift amount is B[4:0]:
  - p0: SRL(A, B) → T0. If latched A[31] == 0, this is the final pass and result = T0.
  - p1: SRL(0xFFFFFFFF, B) → T1.
  - p2: XOR(T1, 0xFFFFFFFF) → T1 (sign mask).
  - p3: OR(T0, T1) → result.
- Illegal encodings: alt=1 with funct3 ∉ {000, 101}, or funct3=000 with alt=1 and `in_is_imm`. No ALU pass is made; EXEC lasts 1 cycle; `out_illegal`=1, `out_data`=0.
- Outside EXEC, `alu_a` = `alu_b` = 0 and `alu_op` = 000.
- `out_zero` = `alu_zero` sampled on the final pass (0 for illegal). It is registered with `out_data`.

## Timing
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `out_data`=0, `out_rd`=0, `out_zero`=0, `out_illegal`=0, `alu_a`=`alu_b`=0, `alu_op`=000, T0=T1=0.
- Accept at edge E0 starts pass p0 in the following cycle. `out_valid` rises at edge E0+N, where N is:
  - 1 for single-pass ops, non-negative SRA, and illegal encodings.
  - 3 for SLTU.
  - 4 for negative SRA.
- `out_data`, `out_rd`, `out_zero` and `out_illegal` are stable while `out_valid && !out_ready`.
- No overlap: `in_ready`=0 in EXEC and DONE; input changes are ignored. The next accept is earliest one cycle after the output handoff.
- Handoff edge: `out_valid` falls and `in_ready` rises at the same edge.
- Reset mid-sequence: async return to IDLE with reset values; the in-flight instruction is discarded and never reported.

## Configuration
- `ALU_SEQ_EMUL_EN` defined: SLTU and SRA are emulated as above.
- Undefined: SLTU (011) and SRA (101, alt=1) are illegal (1 cycle, `out_illegal`=1, `out_data`=0). T0/T1 and the multi-pass logic are removed. Every legal op is single-pass.

## Test plan
- ADD rs1=5, rs2=7 → `out_data`=12, `out_zero`=0; `alu_op`=000 for one cycle; `out_valid` at accept+1.
- SUB rs1=rs2=0x1234 → `out_data`=0, `out_zero`=1; ADDI rs1=3, imm=0xFFFFFFFD → `out_data`=0, `out_zero`=1.
- SLTU with `ALU_SEQ_EMUL_EN`:
  - rs1=0xFFFFFFFF, rs2=1 → 0; rs1=1, rs2=0xFFFFFFFF → 1.
  - `alu_op` sequence 100, 100, 101; `out_valid` at accept+3.
- SRAI with `ALU_SEQ_EMUL_EN`:
  - rs1=0x80000000, imm=4 → 0xF8000000 at accept+4; ops 111, 111, 100, 011.
  - rs1=0x70000000, imm=4 → 0x07000000 at accept+1.
  - rs1=0x80000001, imm=0 → 0x80000001.
- Hold `out_ready`=0 for 5 cycles after SLL rs1=1, rs2=31 → `out_data`=0x80000000 stable, `in_ready`=0; release → handoff, `in_ready`=1. Assert `rst` in the SRA p2 cycle → all outputs at reset values immediately; no `out_valid` follows.
- funct3=001 with alt=1 → `out_illegal`=1, `out_data`=0 at accept+1. Without `ALU_SEQ_EMUL_EN`, SLTU rs1=1, rs2=2 → `out_illegal`=1.

Source files
------------

// File: rtl/alu_sequencer_if.sv
// Decode-side, ALU-side and writeback-side signals of alu_sequencer.
// master is the sequencer's view; slave is the surrounding pipeline/ALU view.
interface alu_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_funct3;
  logic        in_alt;
  logic        in_is_imm;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic [31:0] in_imm;
  logic [4:0]  in_rd;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_op;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic        out_zero;
  logic        out_illegal;

  modport master (
    input  in_valid, in_funct3, in_alt, in_is_imm, in_rs1, in_rs2, in_imm, in_rd,
    output in_ready,
    output alu_a, alu_b, alu_op,
    input  alu_result, alu_zero,
    output out_valid, out_data, out_rd, out_zero, out_illegal,
    input  out_ready
  );

  modport slave (
    output in_valid, in_funct3, in_alt, in_is_imm, in_rs1, in_rs2, in_imm, in_rd,
    input  in_ready,
    input  alu_a, alu_b, alu_op,
    output alu_result, alu_zero,
    input  out_valid, out_data, out_rd, out_zero, out_illegal,
    output out_ready
  );
endinterface

// File: rtl/alu_sequencer.sv
// Execute-stage issuer driving a 32-bit ALU from RV32I OP/OP-IMM instructions.
// Define ALU_SEQ_EMUL_EN to emulate SLTU and SRA as multi-pass ALU sequences.
module alu_sequencer (
  input logic            clk,
  input logic            rst,
  alu_sequencer_if.master bus
);
  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpAnd = 3'b010;
  localparam logic [2:0] OpOr  = 3'b011;
  localparam logic [2:0] OpXor = 3'b100;
  localparam logic [2:0] OpSlt = 3'b101;
  localparam logic [2:0] OpSll = 3'b110;
  localparam logic [2:0] OpSrl = 3'b111;

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] a_q, b_q;
  logic [2:0]  op_q;
  logic        ill_q;
  logic [4:0]  rd_q;
  logic [31:0] data_q, data_d;
  logic        zero_q, zero_d;
  logic        illout_q, illout_d;
  logic        accept, last;
  logic        dec_ill;
  logic [2:0]  dec_op;
  logic [31:0] alu_a, alu_b;
  logic [2:0]  alu_op;
`ifdef ALU_SEQ_EMUL_EN
  localparam logic [31:0] SignBit = 32'h8000_0000;
  localparam logic [31:0] AllOnes = 32'hFFFF_FFFF;
  logic        sltu_q, sra_q;
  logic [1:0]  pass_q, pass_d;
  logic [31:0] t0_q, t0_d, t1_q, t1_d;
`endif

  assign accept = (state_q == StIdle) && bus.in_valid;

  always_comb begin
    dec_ill = (bus.in_alt && bus.in_funct3 != 3'b000 && bus.in_funct3 != 3'b101) ||
              (bus.in_funct3 == 3'b000 && bus.in_alt && bus.in_is_imm);
`ifndef ALU_SEQ_EMUL_EN
    dec_ill = dec_ill || bus.in_funct3 == 3'b011 ||
              (bus.in_funct3 == 3'b101 && bus.in_alt);
`endif
    case (bus.in_funct3)
      3'b000:  dec_op = bus.in_alt ? OpSub : OpAdd;
      3'b001:  dec_op = OpSll;
      3'b010:  dec_op = OpSlt;
      3'b100:  dec_op = OpXor;
      3'b101:  dec_op = OpSrl;
      3'b110:  dec_op = OpOr;
      3'b111:  dec_op = OpAnd;
      default: dec_op = OpAdd; // SLTU is always sequenced or illegal
    endcase
  end

  always_comb begin
    state_d  = state_q;
    alu_a    = '0;
    alu_b    = '0;
    alu_op   = OpAdd;
    last     = 1'b0;
    data_d   = data_q;
    zero_d   = zero_q;
    illout_d = illout_q;
`ifdef ALU_SEQ_EMUL_EN
    pass_d   = pass_q;
    t0_d     = t0_q;
    t1_d     = t1_q;
`endif
    case (state_q)
      StIdle: begin
        if (bus.in_valid) state_d = StExec;
`ifdef ALU_SEQ_EMUL_EN
        pass_d = '0;
`endif
      end
      StExec: begin
        if (ill_q) begin
          last = 1'b1;
`ifdef ALU_SEQ_EMUL_EN
        end else if (sltu_q) begin
          // Bias both operands so a signed compare yields the unsigned order
          case (pass_q)
            2'd0: begin alu_a = a_q;  alu_b = SignBit; alu_op = OpXor; t0_d = bus.alu_result; end
            2'd1: begin alu_a = b_q;  alu_b = SignBit; alu_op = OpXor; t1_d = bus.alu_result; end
            default: begin alu_a = t0_q; alu_b = t1_q; alu_op = OpSlt; last = 1'b1; end
          endcase
        end else if (sra_q) begin
          // Logical shift, then OR in the inverted shifted-ones mask for negative A
          case (pass_q)
            2'd0: begin
              alu_a = a_q; alu_b = b_q; alu_op = OpSrl;
              t0_d  = bus.alu_result;
              last  = !a_q[31];
            end
            2'd1: begin alu_a = AllOnes; alu_b = b_q; alu_op = OpSrl; t1_d = bus.alu_result; end
            2'd2: begin alu_a = t1_q; alu_b = AllOnes; alu_op = OpXor; t1_d = bus.alu_result; end
            default: begin alu_a = t0_q; alu_b = t1_q; alu_op = OpOr; last = 1'b1; end
          endcase
`endif
        end else begin
          alu_a  = a_q;
          alu_b  = b_q;
          alu_op = op_q;
          last   = 1'b1;
        end
`ifdef ALU_SEQ_EMUL_EN
        pass_d = pass_q + 2'd1;
`endif
        if (last) begin
          state_d  = StDone;
          data_d   = ill_q ? '0 : bus.alu_result;
          zero_d   = ill_q ? 1'b0 : bus.alu_zero;
          illout_d = ill_q;
        end
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OpAdd;
      ill_q    <= 1'b0;
      rd_q     <= '0;
      data_q   <= '0;
      zero_q   <= 1'b0;
      illout_q <= 1'b0;
`ifdef ALU_SEQ_EMUL_EN
      sltu_q   <= 1'b0;
      sra_q    <= 1'b0;
      pass_q   <= '0;
      t0_q     <= '0;
      t1_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      zero_q   <= zero_d;
      illout_q <= illout_d;
`ifdef ALU_SEQ_EMUL_EN
      pass_q   <= pass_d;
      t0_q     <= t0_d;
      t1_q     <= t1_d;
`endif
      if (accept) begin
        a_q    <= bus.in_rs1;
        b_q    <= bus.in_is_imm ? bus.in_imm : bus.in_rs2;
        op_q   <= dec_op;
        ill_q  <= dec_ill;
        rd_q   <= bus.in_rd;
`ifdef ALU_SEQ_EMUL_EN
        sltu_q <= !dec_ill && bus.in_funct3 == 3'b011;
        sra_q  <= !dec_ill && bus.in_funct3 == 3'b101 && bus.in_alt;
`endif
      end
    end
  end

  assign bus.in_ready    = (state_q == StIdle);
  assign bus.out_valid   = (state_q == StDone);
  assign bus.out_data    = data_q;
  assign bus.out_rd      = rd_q;
  assign bus.out_zero    = zero_q;
  assign bus.out_illegal = illout_q;
  assign bus.alu_a       = alu_a;
  assign bus.alu_b       = alu_b;
  assign bus.alu_op      = alu_op;
endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a behavioural ALU; expectations follow
// the build's ALU_SEQ_EMUL_EN setting.
module tb_alu_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_sequencer_if bus ();

  alu_sequencer u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [31:0] alu_res;
  always_comb begin
    alu_res = '0;
    case (bus.alu_op)
      3'd0: alu_res = bus.alu_a + bus.alu_b;
      3'd1: alu_res = bus.alu_a - bus.alu_b;
      3'd2: alu_res = bus.alu_a & bus.alu_b;
      3'd3: alu_res = bus.alu_a | bus.alu_b;
      3'd4: alu_res = bus.alu_a ^ bus.alu_b;
      3'd5: alu_res = {31'd0, $signed(bus.alu_a) < $signed(bus.alu_b)};
      3'd6: alu_res = bus.alu_a << bus.alu_b[4:0];
      default: alu_res = bus.alu_a >> bus.alu_b[4:0];
    endcase
  end
  assign bus.alu_result = alu_res;
  assign bus.alu_zero   = (alu_res == 32'd0);

  typedef struct packed {
    logic [31:0]     data;
    logic [4:0]      rd;
    logic            zero;
    logic            ill;
    logic [2:0]      n;
    logic [3:0][2:0] ops;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] f3, input logic alt, input logic is_imm,
                                 input logic [31:0] a, input logic [31:0] rs2,
                                 input logic [31:0] imm, input logic [4:0] rd);
    exp_t        e;
    logic [31:0] b;
    b     = is_imm ? imm : rs2;
    e     = '0;
    e.rd  = rd;
    e.n   = 3'd1;
    e.ill = (alt && f3 != 3'b000 && f3 != 3'b101) || (f3 == 3'b000 && alt && is_imm);
`ifndef ALU_SEQ_EMUL_EN
    e.ill = e.ill || f3 == 3'b011 || (f3 == 3'b101 && alt);
`endif
    case (f3)
      3'b000: begin e.data = alt ? a - b : a + b; e.ops[0] = alt ? 3'd1 : 3'd0; end
      3'b001: begin e.data = a << b[4:0]; e.ops[0] = 3'd6; end
      3'b010: begin e.data = {31'd0, $signed(a) < $signed(b)}; e.ops[0] = 3'd5; end
      3'b011: begin
        e.data = {31'd0, a < b};
        e.n = 3'd3; e.ops[0] = 3'd4; e.ops[1] = 3'd4; e.ops[2] = 3'd5;
      end
      3'b100: begin e.data = a ^ b; e.ops[0] = 3'd4; end
      3'b101: begin
        if (alt) begin
          e.data = $signed(a) >>> b[4:0];
          e.ops[0] = 3'd7;
          if (a[31]) begin
            e.n = 3'd4; e.ops[1] = 3'd7; e.ops[2] = 3'd4; e.ops[3] = 3'd3;
          end
        end else begin
          e.data = a >> b[4:0]; e.ops[0] = 3'd7;
        end
      end
      3'b110: begin e.data = a | b; e.ops[0] = 3'd3; end
      default: begin e.data = a & b; e.ops[0] = 3'd2; end
    endcase
    if (e.ill) begin
      e.data = '0; e.n = 3'd1; e.ops = '0;
    end
    e.zero = !e.ill && (e.data == 32'd0);
    return e;
  endfunction

  task automatic issue(input logic [2:0] f3, input logic alt, input logic is_imm,
                       input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] imm, input logic [4:0] rd);
    @(negedge clk);
    check("in_ready_idle", {31'd0, bus.in_ready}, 32'd1);
    bus.in_funct3 = f3; bus.in_alt = alt; bus.in_is_imm = is_imm;
    bus.in_rs1 = rs1; bus.in_rs2 = rs2; bus.in_imm = imm; bus.in_rd = rd;
    bus.in_valid = 1'b1;
    sb.push_back(model(f3, alt, is_imm, rs1, rs2, imm, rd));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_rs1 = $urandom; bus.in_rs2 = $urandom; bus.in_imm = $urandom;
    bus.in_funct3 = 3'($urandom); bus.in_rd = 5'($urandom);
  endtask

  task automatic collect(input int hold);
    exp_t       e;
    logic [2:0] seen[8];
    int         n;
    bit         got_valid;
    n = 0;
    got_valid = 1'b0;
    while (n < 8 && !got_valid) begin
      @(negedge clk);
      if (bus.out_valid) got_valid = 1'b1;
      else begin
        seen[n] = bus.alu_op;
        n++;
      end
    end
    e = sb.pop_front();
    if (!got_valid) begin
      check("out_valid_timeout", 32'd0, 32'd1);
      return;
    end
    check("latency", n, {29'd0, e.n});
    for (int i = 0; i < int'(e.n) && i < n; i++) check("alu_op_seq", {29'd0, seen[i]}, {29'd0, e.ops[i]});
    check("out_data", bus.out_data, e.data);
    check("out_rd", {27'd0, bus.out_rd}, {27'd0, e.rd});
    check("out_zero", {31'd0, bus.out_zero}, {31'd0, e.zero});
    check("out_illegal", {31'd0, bus.out_illegal}, {31'd0, e.ill});
    for (int h = 0; h < hold; h++) begin
      bus.in_valid = 1'b1;
      @(negedge clk);
      check("hold_data", bus.out_data, e.data);
      check("hold_valid", {31'd0, bus.out_valid}, 32'd1);
      check("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("handoff_valid", {31'd0, bus.out_valid}, 32'd0);
    check("handoff_in_ready", {31'd0, bus.in_ready}, 32'd1);
  endtask

  task automatic check_reset_values();
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_out_data", bus.out_data, 32'd0);
    check("rst_out_rd", {27'd0, bus.out_rd}, 32'd0);
    check("rst_out_zero", {31'd0, bus.out_zero}, 32'd0);
    check("rst_out_illegal", {31'd0, bus.out_illegal}, 32'd0);
    check("rst_alu_a", bus.alu_a, 32'd0);
    check("rst_alu_b", bus.alu_b, 32'd0);
    check("rst_alu_op", {29'd0, bus.alu_op}, 32'd0);
  endtask

  initial begin
    int vcount;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.in_funct3 = '0; bus.in_alt = 1'b0; bus.in_is_imm = 1'b0;
    bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_imm = '0; bus.in_rd = '0;
    repeat (2) @(negedge clk);
    check_reset_values();
    rst = 1'b0;

    issue(3'b000, 1'b0, 1'b0, 32'd5, 32'd7, 32'd0, 5'd1);                 collect(0);
    issue(3'b000, 1'b1, 1'b0, 32'h1234, 32'h1234, 32'd0, 5'd2);           collect(0);
    issue(3'b000, 1'b0, 1'b1, 32'd3, 32'd0, 32'hFFFF_FFFD, 5'd3);         collect(0);
    issue(3'b011, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd4);         collect(0);
    issue(3'b011, 1'b0, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'd0, 5'd5);         collect(0);
    issue(3'b011, 1'b0, 1'b0, 32'd1, 32'd2, 32'd0, 5'd6);                 collect(0);
    issue(3'b101, 1'b1, 1'b1, 32'h8000_0000, 32'd0, 32'd4, 5'd7);         collect(0);
    issue(3'b101, 1'b1, 1'b1, 32'h7000_0000, 32'd0, 32'd4, 5'd8);         collect(0);
    issue(3'b101, 1'b1, 1'b1, 32'h8000_0001, 32'd0, 32'd0, 5'd9);         collect(0);
    issue(3'b001, 1'b0, 1'b0, 32'd1, 32'd31, 32'd0, 5'd10);               collect(5);
    issue(3'b001, 1'b1, 1'b0, 32'd1, 32'd2, 32'd0, 5'd11);                collect(0);
    issue(3'b000, 1'b1, 1'b1, 32'd9, 32'd1, 32'd4, 5'd12);                collect(0);

    for (int i = 0; i < 24; i++) begin
      issue(3'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom),
            $urandom, $urandom, $urandom, 5'($urandom));
      collect(int'($urandom_range(0, 2)));
    end

    // Reset during pass p2 of a negative SRA
    issue(3'b101, 1'b1, 1'b1, 32'hC000_0000, 32'd0, 32'd3, 5'd13);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_values();
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    vcount = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.out_valid) vcount++;
    end
    check("no_valid_after_rst", vcount, 32'd0);

    issue(3'b110, 1'b0, 1'b0, 32'hF0F0_0000, 32'h0000_0F0F, 32'd0, 5'd14); collect(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
